ifetch_unit: RTL and testbench

- Multi-cycle instruction fetch engine for the MIPS micro-system datapath.
- Owns the PC and issues word reads to instruction memory over a req/ack bus that allows wait states.
- Delivers each fetched word with a one-cycle IR write strobe to the instruction register that splits it into op/rs/rt/imm.
- Driven by the main controller's fetch request; accepts PC redirects and interrupt vectoring.

---
 rtl/mips_pkg.sv | 7 +
 rtl/pc_reg.sv | 26 ++
 rtl/ifetch_unit.sv | 65 ++++++
 tb/tb_ifetch_unit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and fetch state encoding for the MIPS micro-system
package mips_pkg;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC = 32'h0000_4180;
  localparam int OP_W = 6;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} fetch_state_t;
endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter with vector/load/increment mux and epc capture
module pc_reg #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter logic [31:0] EXC_VEC = mips_pkg::EXC_VEC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vec,
  input  logic        load,
  input  logic        inc,
  input  logic [31:0] npc,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic [31:0] pc_plus4
);
  assign pc_plus4 = pc + 32'd4;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      epc <= '0;
    end else begin
      if (vec) epc <= pc;
      pc <= vec ? EXC_VEC : load ? npc : inc ? pc_plus4 : pc;
    end
  end
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: multi-cycle instruction fetch over a req/ack bus with timeout and interrupt redirect
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter logic [31:0] EXC_VEC = mips_pkg::EXC_VEC,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_go,
  input  logic        pc_wr,
  input  logic [31:0] npc,
  input  logic        int_req,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  input  logic        im_ack,
  output logic [31:0] instr,
  output logic        ir_wr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] epc,
  output logic        busy,
  output logic        addr_err,
  output logic        bus_err
);
  import mips_pkg::*;
  fetch_state_t state;
  logic [7:0] cnt;
  logic ack_ok, timed_out;
  assign ack_ok = state == REQ && im_ack && !int_req;
  assign timed_out = state == REQ && !im_ack && cnt == 8'(TIMEOUT - 1);
  assign bus_err = !rst && !int_req && timed_out;
  assign im_req = state == REQ;
  assign ir_wr = state == DONE;
  assign busy = state != IDLE;
  assign im_addr = {pc[31:2], 2'b00};
  pc_reg #(.RESET_PC(RESET_PC), .EXC_VEC(EXC_VEC)) u_pc (
    .clk(clk),
    .rst(rst),
    .vec(int_req),
    .load(state == IDLE && pc_wr),
    .inc(ack_ok),
    .npc(npc),
    .pc(pc),
    .epc(epc),
    .pc_plus4(pc_plus4)
  );
  // counter runs only in REQ, so entering REQ from IDLE always starts at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      instr <= '0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= state == IDLE && fetch_go && !pc_wr && !int_req && pc[1:0] != 2'b00;
      if (ack_ok) instr <= im_rdata;
      cnt <= state == REQ ? cnt + 8'd1 : 8'd0;
      if (int_req) state <= IDLE;
      else if (state == IDLE) state <= (fetch_go && !pc_wr && pc[1:0] == 2'b00) ? REQ : IDLE;
      else if (state == REQ) state <= im_ack ? DONE : timed_out ? IDLE : REQ;
      else state <= IDLE;
    end
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed fetch scenarios checked every cycle against a transaction-level model
module tb_ifetch_unit;
  localparam int TO = 16;
  logic clk = 0, rst = 1, fetch_go = 0, pc_wr = 0, int_req = 0, im_ack = 0;
  logic [31:0] npc = '0, im_rdata = '0;
  logic im_req, ir_wr, busy, addr_err, bus_err;
  logic [31:0] im_addr, instr, pc, pc_plus4, epc;
  int tests = 0, fails = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  ifetch_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .fetch_go(fetch_go), .pc_wr(pc_wr), .npc(npc),
    .int_req(int_req), .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata),
    .im_ack(im_ack), .instr(instr), .ir_wr(ir_wr), .pc(pc), .pc_plus4(pc_plus4),
    .epc(epc), .busy(busy), .addr_err(addr_err), .bus_err(bus_err)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // memory: acks after 'waits' wait states, drives junk data when not acking
  int waits = 0, wcnt = 0;
  logic [31:0] mem_data = '0;
  always @(posedge clk) begin
    #1;
    if (im_req && wcnt >= waits) begin
      im_ack = 1; im_rdata = mem_data; wcnt = 0;
    end else begin
      im_ack = 0; im_rdata = 32'hDEAD_BEEF; wcnt = im_req ? wcnt + 1 : 0;
    end
  end
  // transaction-level model
  logic [31:0] m_pc, m_epc, m_instr;
  bit m_fetch, m_dlv, m_aerr, m_valid = 0;
  int m_wait;
  always @(posedge clk) begin
    if (rst) begin
      m_pc = 32'h3000; m_epc = 0; m_instr = 0;
      m_fetch = 0; m_dlv = 0; m_aerr = 0; m_wait = 0; m_valid = 1;
    end else begin
      m_aerr = !m_fetch && !m_dlv && fetch_go && !pc_wr && !int_req && (m_pc % 4 != 0);
      if (int_req) begin
        m_epc = m_pc; m_pc = 32'h4180; m_fetch = 0; m_dlv = 0;
      end else if (m_dlv) m_dlv = 0;
      else if (m_fetch) begin
        if (im_ack) begin
          m_instr = im_rdata; m_pc = m_pc + 4; m_fetch = 0; m_dlv = 1;
        end else if (m_wait == TO - 1) m_fetch = 0;
        else m_wait++;
      end else if (pc_wr) m_pc = npc;
      else if (fetch_go && m_pc % 4 == 0) begin
        m_fetch = 1; m_wait = 0;
      end
    end
  end
  int n_irwr = 0, n_req = 0, n_aerr = 0, n_berr = 0, irwr_cyc = 0, berr_cyc = 0;
  logic [31:0] last_addr = '0;
  always @(negedge clk) begin
    if (m_valid) begin
      chk("pc", pc, m_pc);
      chk("epc", epc, m_epc);
      chk("instr", instr, m_instr);
      chk("pc_plus4", pc_plus4, m_pc + 4);
      chk("im_req", 32'(im_req), 32'(m_fetch));
      chk("ir_wr", 32'(ir_wr), 32'(m_dlv));
      chk("busy", 32'(busy), 32'(m_fetch || m_dlv));
      chk("addr_err", 32'(addr_err), 32'(m_aerr));
      chk("bus_err", 32'(bus_err), 32'(m_fetch && !im_ack && !int_req && !rst && m_wait == TO - 1));
      if (m_fetch) chk("im_addr", im_addr, m_pc & ~32'd3);
    end
    if (ir_wr) begin n_irwr++; irwr_cyc = cyc; end
    if (im_req) begin n_req++; last_addr = im_addr; end
    if (addr_err) n_aerr++;
    if (bus_err) begin n_berr++; berr_cyc = cyc; end
  end
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic fetch(input int w, input logic [31:0] d, output int g);
    waits = w; mem_data = d; fetch_go = 1; g = cyc;
    step(); fetch_go = 0;
    step(w + 3);
  endtask
  initial begin
    int g, a, r, b;
    step(2); rst = 0;
    chk("rst_pc", pc, 32'h3000);
    chk("rst_epc", epc, 0);
    chk("rst_instr", instr, 0);
    chk("rst_im_req", 32'(im_req), 0);
    chk("rst_busy", 32'(busy), 0);
    a = n_irwr;
    fetch(0, 32'h2008_0005, g);
    chk("t1_lat", irwr_cyc - g, 2);
    chk("t1_pulses", n_irwr - a, 1);
    chk("t1_instr", instr, 32'h2008_0005);
    chk("t1_addr", last_addr, 32'h3000);
    chk("t1_pc", pc, 32'h3004);
    a = n_irwr; r = n_req;
    fetch(3, 32'h8C09_0004, g);
    chk("t2_lat", irwr_cyc - g, 5);
    chk("t2_req_cycles", n_req - r, 4);
    chk("t2_pulses", n_irwr - a, 1);
    chk("t2_addr", last_addr, 32'h3004);
    chk("t2_pc", pc, 32'h3008);
    pc_wr = 1; npc = 32'h3002; step(); pc_wr = 0;
    a = n_aerr; r = n_req;
    fetch_go = 1; step(); fetch_go = 0; step(3);
    chk("t3_aerr", n_aerr - a, 1);
    chk("t3_req", n_req - r, 0);
    chk("t3_pc", pc, 32'h3002);
    pc_wr = 1; npc = 32'h3010; step(); pc_wr = 0;
    waits = 1000; a = n_irwr; r = n_req; b = n_berr;
    fetch_go = 1; g = cyc; step(); fetch_go = 0; step(20);
    chk("t4_berr", n_berr - b, 1);
    chk("t4_berr_cyc", berr_cyc - g, 16);
    chk("t4_req_cycles", n_req - r, 16);
    chk("t4_irwr", n_irwr - a, 0);
    chk("t4_pc", pc, 32'h3010);
    waits = 0; mem_data = 32'h1234_5678; a = n_irwr;
    fetch_go = 1; step(); fetch_go = 0; int_req = 1; step(); int_req = 0; step(3);
    chk("t5_epc", epc, 32'h3010);
    chk("t5_pc", pc, 32'h4180);
    chk("t5_instr", instr, 32'h8C09_0004);
    chk("t5_irwr", n_irwr - a, 0);
    fetch(0, 32'h2409_0001, g);
    chk("t5_next_addr", last_addr, 32'h4180);
    chk("t5_next_pc", pc, 32'h4184);
    pc_wr = 1; npc = 32'hFFFF_FFFC; step(); pc_wr = 0;
    fetch(0, 32'h0800_0C00, g);
    chk("t6_addr", last_addr, 32'hFFFF_FFFC);
    chk("t6_pc_wrap", pc, 32'h0);
    waits = 0; mem_data = 32'h3C01_ABCD; a = n_irwr;
    fetch_go = 1; step(); fetch_go = 0; step(); int_req = 1; step(); int_req = 0; step(2);
    chk("t7_irwr", n_irwr - a, 1);
    chk("t7_instr", instr, 32'h3C01_ABCD);
    chk("t7_epc", epc, 32'h4);
    chk("t7_pc", pc, 32'h4180);
    waits = 1000;
    fetch_go = 1; step(); fetch_go = 0; step(3);
    rst = 1; step(); rst = 0;
    chk("t8_im_req", 32'(im_req), 0);
    chk("t8_pc", pc, 32'h3000);
    chk("t8_epc", epc, 0);
    chk("t8_instr", instr, 0);
    step(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
